// File: rtl/sdram_pio_tester.sv
// sdram_pio_tester: PIO-launched SDRAM exerciser that writes TEST_WORDS words of an
// address or LFSR pattern, reads them back in order and counts mismatching words.
module sdram_pio_tester #(
  parameter int ADDR_W     = 22,
  parameter int BASE_ADDR  = 0,
  parameter int TEST_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ctrl,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable_n,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count
);

  localparam int                CNT_W    = $clog2(TEST_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TEST_WORDS - 1);
  localparam logic [CNT_W-1:0]  N_WORDS  = CNT_W'(TEST_WORDS);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       SEED     = 16'hACE1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DONE} state_t;

  function automatic logic [15:0] f_seed(input logic pat);
    return pat ? SEED : 16'h0000;
  endfunction

  // Address mode counts up; LFSR mode steps the Galois register.
  function automatic logic [15:0] f_adv(input logic pat, input logic [15:0] v);
    if (!pat) return v + 16'd1;
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  state_t             r_state, w_state_nxt;
  logic               r_start_d, r_pat_sel, w_pat_sel_nxt;
  logic [CNT_W-1:0]   r_widx, r_ridx, r_rcnt, w_widx_nxt, w_ridx_nxt, w_rcnt_nxt;
  logic [15:0]        r_wgen, r_rgen, w_wgen_nxt, w_rgen_nxt;
  logic [ADDR_W-1:0]  r_address, w_address_nxt;
  logic               r_write_n, r_read_n, w_write_n_nxt, w_read_n_nxt;
  logic [15:0]        r_writedata, w_writedata_nxt;
  logic               r_busy, r_done, r_pass, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic [15:0]        r_err_count, w_err_nxt;

  logic               w_start, w_accept, w_wr_acc, w_rd_acc, w_cmp;
  logic               w_last_wr, w_last_rd, w_all_rx;
  logic [CNT_W-1:0]   w_rcnt_inc;

  // Starts are edge-triggered and dropped outright while a pass is running.
  assign w_start    = ctrl[0] & ~r_start_d;
  assign w_accept   = w_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr_acc   = (r_state == S_WRITE) && !avm_waitrequest;
  assign w_rd_acc   = (r_state == S_READ) && !avm_waitrequest;
  assign w_cmp      = (r_state == S_READ || r_state == S_WAIT) && avm_readdatavalid;
  assign w_last_wr  = w_wr_acc && (r_widx == LAST_IDX);
  assign w_last_rd  = w_rd_acc && (r_ridx == LAST_IDX);
  assign w_rcnt_inc = r_rcnt + CNT_W'(w_cmp);
  assign w_all_rx   = (w_rcnt_inc == N_WORDS);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_pat_sel   <= 1'b0;
      r_widx      <= '0;
      r_ridx      <= '0;
      r_rcnt      <= '0;
      r_wgen      <= '0;
      r_rgen      <= '0;
      r_address   <= '0;
      r_write_n   <= 1'b1;
      r_read_n    <= 1'b1;
      r_writedata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= ctrl[0];
      r_pat_sel   <= w_pat_sel_nxt;
      r_widx      <= w_widx_nxt;
      r_ridx      <= w_ridx_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_wgen      <= w_wgen_nxt;
      r_rgen      <= w_rgen_nxt;
      r_address   <= w_address_nxt;
      r_write_n   <= w_write_n_nxt;
      r_read_n    <= w_read_n_nxt;
      r_writedata <= w_writedata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept)  w_state_nxt = S_WRITE;
      S_WRITE:        if (w_last_wr) w_state_nxt = S_READ;
      S_READ:         if (w_last_rd) w_state_nxt = w_all_rx ? S_DONE : S_WAIT;
      S_WAIT:         if (w_all_rx)  w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Computes next register values so the bus is updated on the same edge as each acceptance.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves one unassigned (no latches).
    w_pat_sel_nxt   = r_pat_sel;
    w_widx_nxt      = r_widx;
    w_ridx_nxt      = r_ridx;
    w_rcnt_nxt      = r_rcnt;
    w_wgen_nxt      = r_wgen;
    w_rgen_nxt      = r_rgen;
    w_address_nxt   = r_address;
    w_write_n_nxt   = r_write_n;
    w_read_n_nxt    = r_read_n;
    w_writedata_nxt = r_writedata;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err_count;

    if (w_accept) begin
      w_pat_sel_nxt   = ctrl[1];
      w_widx_nxt      = '0;
      w_ridx_nxt      = '0;
      w_rcnt_nxt      = '0;
      w_wgen_nxt      = f_seed(ctrl[1]);
      w_rgen_nxt      = f_seed(ctrl[1]);
      w_err_nxt       = '0;
      w_done_nxt      = 1'b0;
      w_busy_nxt      = 1'b1;
      w_write_n_nxt   = 1'b0;
      w_read_n_nxt    = 1'b1;
      w_address_nxt   = BASE;
      w_writedata_nxt = f_seed(ctrl[1]);
    end

    if (w_wr_acc) begin
      w_widx_nxt = r_widx + CNT_W'(1);
      w_wgen_nxt = f_adv(r_pat_sel, r_wgen);
      if (w_last_wr) begin
        w_write_n_nxt = 1'b1;
        w_read_n_nxt  = 1'b0;
        w_address_nxt = BASE;
      end else begin
        w_address_nxt   = BASE + ADDR_W'(w_widx_nxt);
        w_writedata_nxt = w_wgen_nxt;
      end
    end

    if (w_rd_acc) begin
      w_ridx_nxt = r_ridx + CNT_W'(1);
      if (w_last_rd) w_read_n_nxt  = 1'b1;
      else           w_address_nxt = BASE + ADDR_W'(w_ridx_nxt);
    end

    if (w_cmp) begin
      w_rcnt_nxt = w_rcnt_inc;
      w_rgen_nxt = f_adv(r_pat_sel, r_rgen);
      if (avm_readdata != r_rgen && r_err_count != 16'hFFFF)
        w_err_nxt = r_err_count + 16'd1;
    end

    if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b1;
    end

    w_pass_nxt = w_done_nxt && (w_err_nxt == 16'h0000);
  end

  assign avm_address      = r_address;
  assign avm_write_n      = r_write_n;
  assign avm_read_n       = r_read_n;
  assign avm_writedata    = r_writedata;
  assign avm_byteenable_n = 2'b00;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;

endmodule

// File: tb/tb_sdram_pio_tester.sv
// Testbench for sdram_pio_tester: randomized-wait SDRAM slave model with 2-cycle read latency,
// checked against the pattern rules (expected words recomputed from index and seed).
module tb_sdram_pio_tester;

  localparam int AW = 22;
  localparam int N  = 8;

  logic          clk;
  logic          reset_n;
  logic [1:0]    ctrl;
  logic [AW-1:0] avm_address;
  logic          avm_write_n, avm_read_n;
  logic [15:0]   avm_writedata;
  logic [1:0]    avm_byteenable_n;
  logic          avm_waitrequest;
  logic [15:0]   avm_readdata;
  logic          avm_readdatavalid;
  logic          busy, done, pass;
  logic [15:0]   err_count;

  sdram_pio_tester #(.ADDR_W(AW), .BASE_ADDR(0), .TEST_WORDS(N)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ctrl              (ctrl),
    .avm_address       (avm_address),
    .avm_write_n       (avm_write_n),
    .avm_read_n        (avm_read_n),
    .avm_writedata     (avm_writedata),
    .avm_byteenable_n  (avm_byteenable_n),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: word i of a pass, straight from the pattern definition.
  function automatic logic [15:0] exp_word(input bit pat, input int i);
    logic [15:0] v;
    v = 16'hACE1;
    if (!pat) return 16'(i);
    for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Slave model state shared with the stimulus thread.
  logic [15:0] mem [0:255];
  bit          rand_wait = 0;
  int          flip_idx  = -1;
  bit          spur      = 0;
  int          cyc       = 0;
  int          last_vcyc = 0;
  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];
  int            wc[$];
  logic [AW-1:0] ra[$];
  int            rc[$];

  // Slave model: acts on the falling edge, so decisions are in place for the next rising edge.
  initial begin
    logic        pv [0:1];
    logic [15:0] pd [0:1];
    bit          prev_stall;
    logic [63:0] prev_bus;
    pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0;
    prev_stall = 0; prev_bus = '0;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        pv[0] = 0; pv[1] = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {avm_address, avm_writedata, avm_write_n, avm_read_n}, prev_bus);
        avm_waitrequest   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_readdatavalid = pv[1] | spur;
        avm_readdata      = spur ? 16'hDEAD : pd[1];
        if (pv[1]) last_vcyc = cyc;
        spur  = 0;
        pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = 0;
        if (!avm_waitrequest && !avm_write_n) begin
          mem[avm_address[7:0]] = avm_writedata;
          wa.push_back(avm_address); wd.push_back(avm_writedata); wc.push_back(cyc);
        end
        if (!avm_waitrequest && !avm_read_n) begin
          pv[0] = 1;
          pd[0] = mem[avm_address[7:0]] ^ ((int'(avm_address) == flip_idx) ? 16'h0001 : 16'h0000);
          ra.push_back(avm_address); rc.push_back(cyc);
        end
        prev_stall = avm_waitrequest && (!avm_write_n || !avm_read_n);
        prev_bus   = {avm_address, avm_writedata, avm_write_n, avm_read_n};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic run_pass(input bit pat, input bit rnd, input int flip, input bit bounce,
                          input string tag);
    int budget, start_cyc, done_cyc, exp_err;
    rand_wait = rnd;
    flip_idx  = flip;
    exp_err   = (flip >= 0 && flip < N) ? 1 : 0;
    ctrl = {pat, 1'b0};
    tick();
    wa.delete(); wd.delete(); wc.delete(); ra.delete(); rc.delete();
    ctrl = {pat, 1'b1};
    tick();
    start_cyc = cyc;
    check({tag, "_lat_busy"}, busy, 1);
    check({tag, "_lat_wr_n"}, avm_write_n, 0);
    check({tag, "_clr_done"}, done, 0);
    check({tag, "_clr_err"}, err_count, 0);
    budget = 0;
    while (!done && budget < 400) begin
      if (bounce && budget == 2) ctrl = {~pat, 1'b0};
      if (bounce && budget == 4) ctrl[0] = 1'b1;
      tick();
      budget++;
    end
    done_cyc = cyc;
    check({tag, "_no_timeout"}, budget < 400, 1);
    check({tag, "_done_time"}, done_cyc, last_vcyc);
    check({tag, "_nwr"}, wa.size(), N);
    check({tag, "_nrd"}, ra.size(), N);
    for (int i = 0; i < N && i < wa.size(); i++) begin
      check({tag, "_waddr"}, wa[i], AW'(i));
      check({tag, "_wdata"}, wd[i], exp_word(pat, i));
    end
    for (int i = 0; i < N && i < ra.size(); i++) check({tag, "_raddr"}, ra[i], AW'(i));
    check({tag, "_err"}, err_count, exp_err);
    check({tag, "_pass"}, pass, exp_err == 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_strobes"}, {avm_write_n, avm_read_n}, 2'b11);
    if (!rnd && wc.size() == N && rc.size() == N) begin
      check({tag, "_first_wr_cyc"}, wc[0], start_cyc + 1);
      for (int i = 1; i < N; i++) check({tag, "_wr_b2b"}, wc[i], wc[0] + i);
      check({tag, "_turnaround"}, rc[0], wc[N-1] + 1);
      for (int i = 1; i < N; i++) check({tag, "_rd_b2b"}, rc[i], rc[0] + i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ctrl = 2'b00;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_wr_n", avm_write_n, 1);
    check("rst_rd_n", avm_read_n, 1);
    check("rst_flags", {busy, done, pass}, 3'b000);
    check("rst_err", err_count, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_be", avm_byteenable_n, 2'b00);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    run_pass(1'b0, 1'b0, -1, 1'b0, "addr");
    check("addr_done", done, 1);

    run_pass(1'b1, 1'b1, -1, 1'b1, "lfsr");
    if (wd.size() >= 3) begin
      check("lfsr_w0", wd[0], 16'hACE1);
      check("lfsr_w1", wd[1], 16'hE270);
      check("lfsr_w2", wd[2], 16'h7138);
    end

    run_pass(1'b0, 1'b0, 3, 1'b0, "flip");
    check("flip_done", done, 1);
    // ctrl[0] stays high after done; a stray readdatavalid must also be ignored.
    spur = 1;
    repeat (6) tick();
    check("hold_no_restart", busy, 0);
    check("hold_no_writes", wa.size(), N);
    check("hold_done", done, 1);
    check("spur_ignored", err_count, 1);

    run_pass(1'b0, 1'b1, -1, 1'b0, "restart");

    // Reset in the middle of the write phase.
    rand_wait = 0; flip_idx = -1;
    ctrl = 2'b00;
    tick();
    wa.delete(); wd.delete(); wc.delete(); ra.delete(); rc.delete();
    ctrl = 2'b01;
    b = 0;
    while (wa.size() < 4 && b < 50) begin
      tick();
      b++;
    end
    check("rst_reach_w4", wa.size(), 4);
    check("rst_pre_wr_n", avm_write_n, 0);
    reset_n = 1'b0;
    ctrl = 2'b00;
    #1;
    check("midrst_strobes", {avm_write_n, avm_read_n}, 2'b11);
    check("midrst_flags", {busy, done, pass}, 3'b000);
    check("midrst_err", err_count, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    run_pass(1'b0, 1'b0, -1, 1'b0, "after_rst");

    for (int r = 0; r < 4; r++)
      run_pass(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 11)), 1'b0, "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_pio_tester.md
# sdram_pio_tester

Self-checking SDRAM exerciser driven by the 2-bit PIO control word that the Nios II writes, and placed between that PIO's output port and an Avalon-MM port of the SDRAM controller. A rising edge on the start bit launches one pass: write TEST_WORDS words of a selected pattern from BASE_ADDR, read them back, and compare each word. Busy, done and pass flags plus an error count are returned so firmware can poll them through an input PIO.

## Interface
- ADDR_W, 22: word-address width of the SDRAM Avalon port.
- BASE_ADDR, 0: first word address tested.
- TEST_WORDS, 256: words per pass; valid range 1 to 2^ADDR_W − BASE_ADDR.

- clk  in  1  system clock; all logic is on this single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl  in  2  PIO output word. Bit 0 is start (rising edge only). Bit 1 selects the pattern: 0 = address, 1 = LFSR.
- avm_address  out  ADDR_W  word address.
- avm_write_n  out  1  active-low write request.
- avm_read_n  out  1  active-low read request.
- avm_writedata  out  16  write data.
- avm_byteenable_n  out  2  tied to 2'b00.
- avm_waitrequest  in  1  slave stall; the request is held while this is 1.
- avm_readdata  in  16  read data.
- avm_readdatavalid  in  1  read data qualifier; data returns in order and pipelined.
- busy  out  1  a pass is in progress.
- done  out  1  the pass completed; sticky until the next start.
- pass  out  1  equals done && err_count == 0.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.

## Operation
- Start detection:
  - start_d is a register holding the previous ctrl[0]; it resets to 0.
  - start = ctrl[0] & ~start_d.
  - A start is honoured only in IDLE or DONE. A start during WRITE, READ or WAIT is ignored and the edge is discarded.
- On an accepted start:
  - pat_sel is latched from ctrl[1]. Later changes to ctrl[1] have no effect on the running pass.
  - done and err_count are cleared, busy is set, and all counters and generators are reset.
- States: IDLE → WRITE → READ → WAIT → DONE. DONE goes back to WRITE on the next accepted start.
- WRITE:
  - Drive avm_write_n=0, avm_address=BASE_ADDR+widx, avm_writedata=wgen.
  - When avm_waitrequest=0, the word is accepted: widx increments and wgen advances.
  - After word TEST_WORDS−1 is accepted, go to READ with avm_write_n=1.
- READ:
  - Drive avm_read_n=0, avm_address=BASE_ADDR+ridx, and advance ridx on each acceptance.
  - After the last read is accepted, go to WAIT with avm_read_n=1.
- WAIT: hold until rcnt == TEST_WORDS, then go to DONE.
- Compare:
  - Active in READ and WAIT on every cycle with avm_readdatavalid=1.
  - avm_readdata is compared with rgen; on mismatch err_count increments (with saturation).
  - rcnt increments and rgen advances.
  - avm_readdatavalid in IDLE or DONE is ignored.
- Patterns:
  - Address mode: the data for word index i is i[15:0].
  - LFSR mode: 16-bit Galois LFSR, seed 16'hACE1. Next value = lsb ? (v>>1)^16'hB400 : v>>1.
  - wgen and rgen are independent generators; both are reseeded at start.
- Address arithmetic:
  - BASE_ADDR+index is computed at ADDR_W bits and wraps modulo 2^ADDR_W.
  - Index counters are wide enough to hold TEST_WORDS without overflow.
- Reset mid-pass: all state returns to IDLE and all outputs go to their reset values asynchronously. No handshake completion is attempted.

## Timing
- Reset values: avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0, busy=0, done=0, pass=0, err_count=0, state IDLE.
- All outputs are registered.
- Start latency: ctrl[0] is sampled 1 with start_d=0 at edge N; busy=1 and the first write request are driven from edge N+1.
- Throughput: one write or one read is accepted per cycle when avm_waitrequest=0, with no bubbles within a phase.
- Phase turnaround: the first read is driven in the cycle after the last write is accepted (zero idle cycles).
- Completion: the final readdatavalid is sampled at edge M. At edge M+1, done=1, busy=0, and err_count and pass are final.
- avm_address, avm_writedata and the strobes are stable while avm_waitrequest=1.

## Test plan
- Reset: assert reset_n=0 mid-simulation. Immediately: write_n=read_n=1, busy=done=pass=0, err_count=0.
- Address mode, TEST_WORDS=8, zero-wait memory model with 2-cycle read latency:
  - Writes data 0..7 to addresses 0..7 on 8 consecutive cycles, followed by 8 consecutive reads.
  - Ends with done=1, pass=1, err_count=0.
- LFSR mode with random waitrequest:
  - Write data sequence is 16'hACE1, 16'hE270, 16'h7138, … and is held stable while stalled.
  - Ends with pass=1.
- Memory model flips bit 0 of word 3:
  - Ends with done=1, pass=0, err_count=1.
- Start edge while busy and ctrl[0] held high after done:
  - Neither restarts the pass.
  - A low-then-high on ctrl[0] restarts the pass and clears err_count.
- Reset during WRITE at widx=4:
  - Strobes deassert immediately.
  - The next start writes from index 0 at BASE_ADDR.
